// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel shared-counter PWM with shadowed period/duty/mode; optional macro PWM_MULTI_POLARITY_EN
module pwm_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk_in,
  input  logic                      rst,
  input  logic                      en,
  input  logic [WIDTH-1:0]          period,
  input  logic                      mode,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic                      load,
`ifdef PWM_MULTI_POLARITY_EN
  input  logic [CHANNELS-1:0]       polarity,
`endif
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      sync_out,
  output logic                      load_ack
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DOWN} state_e;

  state_e                    state_q, state_d;
  logic [WIDTH-1:0]          cnt_q, cnt_d;

  logic [WIDTH-1:0]          act_period_q, act_period_d;
  logic                      act_mode_q, act_mode_d;
  logic [CHANNELS*WIDTH-1:0] act_duty_q, act_duty_d;

  logic [WIDTH-1:0]          pnd_period_q, pnd_period_d;
  logic                      pnd_mode_q, pnd_mode_d;
  logic [CHANNELS*WIDTH-1:0] pnd_duty_q, pnd_duty_d;
  logic                      pend_q, pend_d;

  logic [CHANNELS-1:0]       pwm_q, pwm_d;
  logic                      sync_q, sync_d;
  logic                      ack_stage_q, ack_stage_d;
  logic                      ack_q, ack_d;

  logic                      down;
  logic                      tc;
  logic                      apply_direct;
  logic                      apply_pend;

  assign down = (state_q == ST_DOWN);

  // Terminal count: last cycle of the current period (never while disabled)
  always_comb begin
    tc = 1'b0;
    if (!en) begin
      tc = 1'b0;
    end else if (act_mode_q && (act_period_q > ONE)) begin
      tc = down && (cnt_q == ONE);
    end else begin
      tc = !down && (cnt_q == act_period_q);
    end
  end

  // Counter FSM next state: idle clears, terminal count restarts upward, centre mode turns at P
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = ZERO;
    end else if (tc) begin
      state_d = ST_UP;
      cnt_d   = ZERO;
    end else if (down) begin
      state_d = ST_DOWN;
      cnt_d   = cnt_q - ONE;
    end else if (act_mode_q && (cnt_q == act_period_q)) begin
      state_d = ST_DOWN;
      cnt_d   = cnt_q - ONE;
    end else begin
      state_d = ST_UP;
      cnt_d   = cnt_q + ONE;
    end
  end

  // Shadow registers: a load in the boundary cycle goes straight to active, otherwise via pending
  always_comb begin
    act_period_d = act_period_q;
    act_mode_d   = act_mode_q;
    act_duty_d   = act_duty_q;
    pnd_period_d = pnd_period_q;
    pnd_mode_d   = pnd_mode_q;
    pnd_duty_d   = pnd_duty_q;
    pend_d       = pend_q;
    apply_direct = tc && load;
    apply_pend   = 1'b0;
    if (apply_direct) begin
      act_period_d = period;
      act_mode_d   = mode;
      act_duty_d   = duty_in;
      pend_d       = 1'b0;
    end else begin
      if (pend_q && (tc || !en)) begin
        act_period_d = pnd_period_q;
        act_mode_d   = pnd_mode_q;
        act_duty_d   = pnd_duty_q;
        pend_d       = 1'b0;
        apply_pend   = 1'b1;
      end
      if (load) begin
        pnd_period_d = period;
        pnd_mode_d   = mode;
        pnd_duty_d   = duty_in;
        pend_d       = 1'b1;
      end
    end
  end

  // Output next state; load_ack is delayed one extra stage so it lines up with the first sync of the new settings
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = en && (cnt_q < act_duty_q[i*WIDTH +: WIDTH]);
    end
    sync_d      = en && !down && (cnt_q == ZERO);
    ack_stage_d = apply_direct || apply_pend;
    ack_d       = ack_stage_q;
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= ZERO;
      act_period_q <= ZERO;
      act_mode_q   <= 1'b0;
      act_duty_q   <= '0;
      pnd_period_q <= ZERO;
      pnd_mode_q   <= 1'b0;
      pnd_duty_q   <= '0;
      pend_q       <= 1'b0;
      pwm_q        <= '0;
      sync_q       <= 1'b0;
      ack_stage_q  <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      act_period_q <= act_period_d;
      act_mode_q   <= act_mode_d;
      act_duty_q   <= act_duty_d;
      pnd_period_q <= pnd_period_d;
      pnd_mode_q   <= pnd_mode_d;
      pnd_duty_q   <= pnd_duty_d;
      pend_q       <= pend_d;
      pwm_q        <= pwm_d;
      sync_q       <= sync_d;
      ack_stage_q  <= ack_stage_d;
      ack_q        <= ack_d;
    end
  end

`ifdef PWM_MULTI_POLARITY_EN
  // Polarity is applied after the register so the idle level is also driven while reset is held
  assign pwm_out = pwm_q ^ polarity;
`else
  assign pwm_out = pwm_q;
`endif
  assign sync_out = sync_q;
  assign load_ack = ack_q;

endmodule
